vga_cfg_sequencer: RTL and testbench

Upstream configuration stage for the VGA timing block. Holds a host-writable shadow copy of the VGA configuration register space, tracks which entries changed, and on a commit request streams only the changed entries into the VGA block over its `c_valid`/`c_addr`/`c_data`/`c_ready` port. Optionally defers the stream to the start of vertical sync so that timing changes never tear a visible frame.

---
 rtl/vga_cfg_pkg.sv | 24 ++
 rtl/vga_cfg_sequencer_if.sv | 26 ++
 rtl/vga_cfg_shadow.sv | 43 ++++
 rtl/vga_cfg_sequencer.sv | 160 ++++++++++++++++
 tb/tb_vga_cfg_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_cfg_pkg.sv
// Shared types and constants for the VGA configuration sequencer.
// Holds the FSM state encoding, default sizing and the named VGA register addresses.
package vga_cfg_pkg;

  localparam int DEF_CONFIG_WIDTH = 4;
  localparam int DEF_NUM_REGS     = 2 ** DEF_CONFIG_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_SCAN,
    ST_SEND,
    ST_DONE
  } state_t;

  // Register map of the downstream VGA timing block
  localparam logic [DEF_CONFIG_WIDTH-1:0] ADDR_H_MARGIN     = 4'd0;
  localparam logic [DEF_CONFIG_WIDTH-1:0] ADDR_V_MARGIN     = 4'd1;
  localparam logic [DEF_CONFIG_WIDTH-1:0] ADDR_H_SYNC_PULSE = 4'd2;
  localparam logic [DEF_CONFIG_WIDTH-1:0] ADDR_V_SYNC_PULSE = 4'd3;
  localparam logic [DEF_CONFIG_WIDTH-1:0] ADDR_H_COUNT_MAX  = 4'd4;
  localparam logic [DEF_CONFIG_WIDTH-1:0] ADDR_V_COUNT_MAX  = 4'd5;

endpackage

// File: rtl/vga_cfg_sequencer_if.sv
// Config write port between the sequencer (master) and the VGA timing block (slave).
// A write is transferred on any rising edge where c_valid and c_ready are both high.
interface vga_cfg_sequencer_if #(
  parameter int CONFIG_WIDTH = 4
) ();

  logic                    c_valid;
  logic [CONFIG_WIDTH-1:0] c_addr;
  logic [CONFIG_WIDTH-1:0] c_data;
  logic                    c_ready;

  modport master (
    output c_valid,
    output c_addr,
    output c_data,
    input  c_ready
  );

  modport slave (
    input  c_valid,
    input  c_addr,
    input  c_data,
    output c_ready
  );

endinterface

// File: rtl/vga_cfg_shadow.sv
// Shadow copy of the VGA register space with one dirty bit per entry.
// Host writes always land; a same-cycle clear of the written entry loses to the write.
module vga_cfg_shadow
  import vga_cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [CONFIG_WIDTH-1:0] wr_addr,
  input  logic [CONFIG_WIDTH-1:0] wr_data,
  input  logic [CONFIG_WIDTH-1:0] rd_idx,
  input  logic                    clr_dirty,
  output logic [CONFIG_WIDTH-1:0] rd_data,
  output logic                    rd_dirty
);

  logic [CONFIG_WIDTH-1:0] shadow [NUM_REGS];
  logic [NUM_REGS-1:0]     dirty;

  // NOTE: this array is small and a reset must discard stale configuration,
  // so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      dirty <= '0;
    end else begin
      // NOTE: non-blocking assignments; the later set overrides the earlier
      // clear in the same cycle, which gives the host write priority.
      if (clr_dirty) dirty[rd_idx] <= 1'b0;
      if (we) begin
        shadow[wr_addr] <= wr_data;
        dirty[wr_addr]  <= 1'b1;
      end
    end
  end

  assign rd_data  = shadow[rd_idx];
  assign rd_dirty = dirty[rd_idx];

endmodule

// File: rtl/vga_cfg_sequencer.sv
// Streams changed shadow entries to the VGA timing block on commit.
// Define VGA_CFG_VSYNC_ALIGN_EN to defer each round to the next VSync falling edge.
module vga_cfg_sequencer
  import vga_cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    host_we,
  input  logic [CONFIG_WIDTH-1:0] host_addr,
  input  logic [CONFIG_WIDTH-1:0] host_data,
  input  logic                    commit,
  input  logic                    VSync,
  output logic                    busy,
  output logic                    done,
  vga_cfg_sequencer_if.master     cfg
);

  localparam logic [CONFIG_WIDTH-1:0] LAST_IDX = CONFIG_WIDTH'(NUM_REGS - 1);

  state_t                  state, state_next;
  logic [CONFIG_WIDTH-1:0] ptr, ptr_next;
  logic [CONFIG_WIDTH-1:0] addr_q, addr_next;
  logic [CONFIG_WIDTH-1:0] data_q, data_next;
  logic                    valid_q, valid_next;
  logic                    done_next, busy_next;
  logic                    pending, pending_next;
  logic                    clr_dirty;
  logic [CONFIG_WIDTH-1:0] rd_data;
  logic                    rd_dirty;

`ifdef VGA_CFG_VSYNC_ALIGN_EN
  localparam state_t START_STATE = ST_WAIT_VS;
  logic vs_q;
  logic vs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= 1'b0;
    else        vs_q <= VSync;
  end

  assign vs_fall = vs_q & ~VSync;
`else
  localparam state_t START_STATE = ST_SCAN;
  logic unused_vsync;
  assign unused_vsync = VSync;
`endif

  vga_cfg_shadow #(
    .CONFIG_WIDTH (CONFIG_WIDTH),
    .NUM_REGS     (NUM_REGS)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (host_we),
    .wr_addr   (host_addr),
    .wr_data   (host_data),
    .rd_idx    (ptr),
    .clr_dirty (clr_dirty),
    .rd_data   (rd_data),
    .rd_dirty  (rd_dirty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      addr_q  <= addr_next;
      data_q  <= data_next;
      valid_q <= valid_next;
      done    <= done_next;
      busy    <= busy_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    state_next   = state;
    ptr_next     = ptr;
    addr_next    = addr_q;
    data_next    = data_q;
    valid_next   = valid_q;
    done_next    = 1'b0;
    pending_next = pending;
    clr_dirty    = 1'b0;

    if (commit && state != ST_IDLE) pending_next = 1'b1;

    case (state)
      ST_IDLE: begin
        if (commit) begin
          ptr_next   = '0;
          state_next = START_STATE;
        end
      end
`ifdef VGA_CFG_VSYNC_ALIGN_EN
      ST_WAIT_VS: begin
        if (vs_fall) state_next = ST_SCAN;
      end
`endif
      ST_SCAN: begin
        if (rd_dirty) begin
          addr_next  = ptr;
          data_next  = rd_data;
          valid_next = 1'b1;
          state_next = ST_SEND;
        end else if (ptr == LAST_IDX) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else begin
          ptr_next = ptr + CONFIG_WIDTH'(1);
        end
      end
      ST_SEND: begin
        if (cfg.c_ready) begin
          valid_next = 1'b0;
          clr_dirty  = 1'b1;
          if (ptr == LAST_IDX) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            ptr_next   = ptr + CONFIG_WIDTH'(1);
            state_next = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        // A commit landing in this very cycle is honoured like a pending one
        if (pending || commit) begin
          pending_next = 1'b0;
          ptr_next     = '0;
          state_next   = START_STATE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE) || pending_next;
  end

  assign cfg.c_valid = valid_q;
  assign cfg.c_addr  = addr_q;
  assign cfg.c_data  = data_q;

endmodule

// File: tb/tb_vga_cfg_sequencer.sv
// Directed bench for vga_cfg_sequencer: reset, empty round, ordered transfers,
// back-pressure, write-wins, collapsed commits, async reset and VSync alignment.
module tb_vga_cfg_sequencer;
  import vga_cfg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_we;
  logic [3:0] host_addr;
  logic [3:0] host_data;
  logic       commit;
  logic       VSync;
  logic       busy;
  logic       done;

  vga_cfg_sequencer_if #(.CONFIG_WIDTH(4)) cfg_bus ();

  vga_cfg_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_data (host_data),
    .commit    (commit),
    .VSync     (VSync),
    .busy      (busy),
    .done      (done),
    .cfg       (cfg_bus.master)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [3:0] xa [4];
  logic [3:0] xd [4];
  int         xn;
  bit         done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // Returns at the negedge right after the FSM has entered SCAN with ptr 0
  task automatic start_round();
    @(negedge clk);
    commit = 1'b1; VSync = 1'b1;
    @(negedge clk);
    commit = 1'b0;
`ifdef VGA_CFG_VSYNC_ALIGN_EN
    VSync = 1'b0;
    @(negedge clk);
    VSync = 1'b1;
`endif
  endtask

  task automatic pulse_commit();
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
  endtask

  task automatic collect(input int bound);
    xn = 0;
    done_seen = 1'b0;
    for (int c = 0; c < bound && !done_seen; c++) begin
      @(negedge clk);
      if (cfg_bus.c_valid && cfg_bus.c_ready) begin
        if (xn < 4) begin xa[xn] = cfg_bus.c_addr; xd[xn] = cfg_bus.c_data; end
        xn++;
      end
      if (done) done_seen = 1'b1;
    end
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (cfg_bus.c_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic empty_round(input string tag);
    int cyc;
    bit saw;
    cyc = 0;
    saw = 1'b0;
    start_round();
    check({tag, "_busy_during"}, busy, 1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cfg_bus.c_valid) saw = 1'b1;
    end
    check({tag, "_done_cycles"}, cyc, 16);
    check({tag, "_no_valid"}, saw, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    bit ok;
    bit found;
    bit busy_drop;
    int ndone;
    int extra;

    rst_n = 1'b0; host_we = 1'b0; host_addr = '0; host_data = '0;
    commit = 1'b0; VSync = 1'b1; cfg_bus.c_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_c_valid", cfg_bus.c_valid, 0);
    check("rst_c_addr", cfg_bus.c_addr, 0);
    check("rst_c_data", cfg_bus.c_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Commit with nothing dirty
    empty_round("empty");

    // Two dirty entries, ready tied high: ascending address order
    host_write(4'd11, 4'd2);
    host_write(4'd8, 4'd1);
    start_round();
    collect(60);
    check("two_done", done_seen, 1);
    check("two_count", xn, 2);
    check("two_a0", xa[0], 8);
    check("two_d0", xd[0], 1);
    check("two_a1", xa[1], 11);
    check("two_d1", xd[1], 2);

    // Back-pressure on the first transfer
    host_write(4'd11, 4'd2);
    host_write(4'd8, 4'd1);
    cfg_bus.c_ready = 1'b0;
    start_round();
    wait_valid(40, ok);
    check("stall_valid_seen", ok, 1);
    check("stall_addr_0", cfg_bus.c_addr, 8);
    check("stall_data_0", cfg_bus.c_data, 1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_valid_%0d", i), cfg_bus.c_valid, 1);
      check($sformatf("stall_addr_%0d", i), cfg_bus.c_addr, 8);
      check($sformatf("stall_data_%0d", i), cfg_bus.c_data, 1);
    end
    cfg_bus.c_ready = 1'b1;
    collect(60);
    check("stall_done", done_seen, 1);
    check("stall_rest_count", xn, 1);
    check("stall_rest_addr", xa[0], 11);
    check("stall_rest_data", xd[0], 2);

    // Host write coincident with the handshake keeps the entry dirty
    host_write(4'd11, 4'd3);
    start_round();
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cfg_bus.c_valid && cfg_bus.c_addr == 4'd11) begin found = 1'b1; break; end
    end
    check("ww_found", found, 1);
    check("ww_old_data", cfg_bus.c_data, 3);
    host_we = 1'b1; host_addr = 4'd11; host_data = 4'd7;
    @(negedge clk);
    host_we = 1'b0;
    collect(40);
    check("ww_round1_done", done_seen, 1);
    check("ww_round1_no_more", xn, 0);
    start_round();
    collect(60);
    check("ww_round2_done", done_seen, 1);
    check("ww_round2_count", xn, 1);
    check("ww_round2_addr", xa[0], 11);
    check("ww_round2_data", xd[0], 7);

    // Two commits during a busy round collapse into one extra round
    host_write(4'd3, 4'd9);
    start_round();
    pulse_commit();
    pulse_commit();
    ndone = 0;
    busy_drop = 1'b0;
    for (int c = 0; c < 200 && ndone < 2; c++) begin
      @(negedge clk);
`ifdef VGA_CFG_VSYNC_ALIGN_EN
      VSync = (c % 4) != 3;
`endif
      if (done) ndone++;
      else if (!busy) busy_drop = 1'b1;
    end
    VSync = 1'b1;
    check("pend_done_count", ndone, 2);
    check("pend_busy_gap", busy_drop, 0);
    @(negedge clk);
    check("pend_busy_after", busy, 0);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("pend_no_third", extra, 0);

    // Asynchronous reset while a transfer is stalled
    host_write(4'd5, 4'd4);
    cfg_bus.c_ready = 1'b0;
    start_round();
    wait_valid(40, ok);
    check("arst_valid_seen", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_c_valid", cfg_bus.c_valid, 0);
    check("arst_c_addr", cfg_bus.c_addr, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_bus.c_ready = 1'b1;
    empty_round("post_rst");

`ifdef VGA_CFG_VSYNC_ALIGN_EN
    // Commit while VSync is already low waits for the next falling edge
    host_write(4'd0, 4'd6);
    VSync = 1'b0;
    pulse_commit();
    found = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cfg_bus.c_valid) found = 1'b1;
    end
    VSync = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (cfg_bus.c_valid) found = 1'b1;
    end
    check("vs_no_early_valid", found, 0);
    VSync = 1'b0;
    @(negedge clk);
    check("vs_fall_cycle", cfg_bus.c_valid, 0);
    @(negedge clk);
    check("vs_after_fall", cfg_bus.c_valid, 1);
    check("vs_addr", cfg_bus.c_addr, 0);
    check("vs_data", cfg_bus.c_data, 6);
    collect(40);
    check("vs_done", done_seen, 1);
    VSync = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
